// File: rtl/tone_pkg.sv
// Shared types and constants for the voice tone shaper.
package tone_pkg;

    // ADSR envelope state; the encoding is visible on env_state.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } adsr_state_t;

    // wave_sel encodings.
    typedef enum logic [1:0] {
        WaveSaw    = 2'd0,
        WaveSquare = 2'd1,
        WaveTri    = 2'd2,
        WaveNoise  = 2'd3
    } wave_t;

    localparam logic [7:0] LfsrSeed = 8'h01;
    localparam logic [7:0] LfsrMask = 8'hB8;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        logic [7:0] shifted;
        shifted = cur >> 1;
        return cur[0] ? (shifted ^ LfsrMask) : shifted;
    endfunction

endpackage

// File: rtl/tone_shaper_if.sv
// Voice-side bus of the tone shaper: phase/period from the counter, key and
// envelope controls in, shaped sample and envelope status out.
interface tone_shaper_if #(
    parameter int unsigned RATE_W = 16
);
    logic [7:0]        count;
    logic [7:0]        count_to;
    logic [1:0]        wave_sel;
    logic              gate;
    logic [7:0]        attack_step;
    logic [7:0]        decay_step;
    logic [7:0]        release_step;
    logic [7:0]        sustain_lvl;
    logic [RATE_W-1:0] tick_div;
    logic [7:0]        sample;
    logic [7:0]        env;
    logic [2:0]        env_state;
    logic              active;

    // Voice controller / upstream side.
    modport master (
        output count, count_to, wave_sel, gate,
        output attack_step, decay_step, release_step, sustain_lvl, tick_div,
        input  sample, env, env_state, active
    );

    // Tone shaper side.
    modport slave (
        input  count, count_to, wave_sel, gate,
        input  attack_step, decay_step, release_step, sustain_lvl, tick_div,
        output sample, env, env_state, active
    );

endinterface

// File: rtl/adsr_env.sv
// ADSR envelope generator: tick prescaler, key-gate edge detect and the
// envelope state machine with registered level and state.
module adsr_env
    import tone_pkg::*;
#(
    parameter int unsigned RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gate,
    input  logic [7:0]        attack_step,
    input  logic [7:0]        decay_step,
    input  logic [7:0]        release_step,
    input  logic [7:0]        sustain_lvl,
    input  logic [RATE_W-1:0] tick_div,
    output logic [7:0]        env,
    output adsr_state_t       env_state
);

    logic [RATE_W-1:0] pre_q;
    logic              tick;
    logic              gate_q;
    logic              rise;

    logic [8:0]        attack_sum;
    logic              attack_full;
    logic              decay_done;
    logic              release_done;

    // >= rather than == so a tick_div lowered below the running count
    // still terminates on the next clock instead of wrapping the counter.
    assign tick = (pre_q >= tick_div);
    assign rise = gate & ~gate_q;

    // Envelope step arithmetic, evaluated against the current level.
    always_comb begin
        attack_sum   = {1'b0, env} + {1'b0, attack_step};
        attack_full  = (attack_step == 8'd0) || (attack_sum >= 9'd255);
        decay_done   = (decay_step == 8'd0) || (env <= sustain_lvl) ||
                       ((env - sustain_lvl) <= decay_step);
        release_done = (release_step == 8'd0) || (env <= release_step);
    end

    // Tick prescaler: counts 0..tick_div, then restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Registered gate for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
        end
    end

    // Envelope FSM; key events take priority over tick-driven stepping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            env       <= 8'd0;
            env_state <= StIdle;
        end else if (rise) begin
            // Retrigger keeps the current level so there is no click.
            env_state <= StAttack;
        end else if (!gate && (env_state inside {StAttack, StDecay, StSustain})) begin
            env_state <= StRelease;
        end else begin
            unique case (env_state)
                StIdle: begin
                    env <= 8'd0;
                end
                StAttack: begin
                    if (tick) begin
                        if (attack_full) begin
                            env       <= 8'hFF;
                            env_state <= StDecay;
                        end else begin
                            env <= attack_sum[7:0];
                        end
                    end
                end
                StDecay: begin
                    if (tick) begin
                        if (decay_done) begin
                            env       <= sustain_lvl;
                            env_state <= StSustain;
                        end else begin
                            env <= env - decay_step;
                        end
                    end
                end
                StSustain: begin
                    // Follow live sustain changes every clock.
                    env <= sustain_lvl;
                end
                StRelease: begin
                    if (tick) begin
                        if (release_done) begin
                            env       <= 8'd0;
                            env_state <= StIdle;
                        end else begin
                            env <= env - release_step;
                        end
                    end
                end
                default: begin
                    env       <= 8'd0;
                    env_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/tone_shaper.sv
// Tone shaper top: forms the raw waveform from the phase counter, runs the
// noise LFSR, and multiplies by the ADSR envelope into a registered sample.
module tone_shaper
    import tone_pkg::*;
#(
    parameter int unsigned RATE_W = 16
) (
    input logic         clk,
    input logic         rst,
    tone_shaper_if.slave bus
);

    logic [7:0]  top_e;
    logic [7:0]  half;
    logic [7:0]  tri_t;
    logic [8:0]  tri_dbl;
    logic [7:0]  tri_raw;
    logic [7:0]  square_raw;
    logic [7:0]  raw;
    logic        wrap;

    logic [7:0]  prev_count;
    logic [7:0]  lfsr_q;
    logic [7:0]  raw_q;
    logic [7:0]  sample_q;

    logic [7:0]  env;
    adsr_state_t env_state;

    // count_to == 0 means a full 0..255 period.
    assign top_e = (bus.count_to == 8'd0) ? 8'hFF : bus.count_to;
    assign half  = top_e >> 1;
    assign wrap  = (bus.count < prev_count);

    // Square and triangle shapes derived from the phase and period top.
    always_comb begin
        square_raw = (bus.count > half) ? 8'hFF : 8'h00;
        tri_t      = (bus.count <= half) ? bus.count : (top_e - bus.count);
        tri_dbl    = {tri_t, 1'b0};
        tri_raw    = tri_dbl[8] ? 8'hFF : tri_dbl[7:0];
    end

    // Waveform select.
    always_comb begin
        raw = bus.count;
        unique case (wave_t'(bus.wave_sel))
            WaveSaw:    raw = bus.count;
            WaveSquare: raw = square_raw;
            WaveTri:    raw = tri_raw;
            WaveNoise:  raw = lfsr_q;
        endcase
    end

    // Previous phase for wrap detection; LFSR advances once per wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_count <= 8'd0;
            lfsr_q     <= LfsrSeed;
        end else begin
            prev_count <= bus.count;
            if (wrap) begin
                lfsr_q <= lfsr_next(lfsr_q);
            end
        end
    end

    // Stage 1: register the raw waveform.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q <= 8'd0;
        end else begin
            raw_q <= raw;
        end
    end

    // Stage 2: scale by the envelope, keep the high byte of the product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= 8'd0;
        end else begin
            sample_q <= 8'((16'(raw_q) * 16'(env)) >> 8);
        end
    end

    adsr_env #(
        .RATE_W (RATE_W)
    ) u_adsr (
        .clk          (clk),
        .rst          (rst),
        .gate         (bus.gate),
        .attack_step  (bus.attack_step),
        .decay_step   (bus.decay_step),
        .release_step (bus.release_step),
        .sustain_lvl  (bus.sustain_lvl),
        .tick_div     (bus.tick_div),
        .env          (env),
        .env_state    (env_state)
    );

    assign bus.sample    = sample_q;
    assign bus.env       = env;
    assign bus.env_state = env_state;
    assign bus.active    = (env_state != StIdle);

endmodule

// File: tb/tb_tone_shaper.sv
// Self-checking bench for tone_shaper: cycle model built from the waveform
// and envelope rules, directed pins with hand-computed values, random run.
module tb_tone_shaper;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tone_shaper_if #(.RATE_W(16)) bus ();

    tone_shaper #(
        .RATE_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    int q[$];
    int exp_ad[8]  = '{64, 128, 192, 255, 223, 191, 159, 128};
    int exp_rel[8] = '{112, 96, 80, 64, 48, 32, 16, 0};
    int exp_ret[3] = '{144, 208, 255};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_prev, m_lfsr, m_raw, m_sample, m_env, m_state, m_gq, m_pre;

    always @(posedge clk or negedge rst) begin : model_step
        int cnt, e, h, t, raw, ne, ns, as, ds, rs, sus;
        bit tick, rise;
        if (!rst) begin
            m_prev <= 0; m_lfsr <= 1; m_raw <= 0; m_sample <= 0;
            m_env <= 0; m_state <= 0; m_gq <= 0; m_pre <= 0;
        end else begin
            cnt = int'(bus.count);
            as  = int'(bus.attack_step);
            ds  = int'(bus.decay_step);
            rs  = int'(bus.release_step);
            sus = int'(bus.sustain_lvl);
            e   = (bus.count_to == 8'd0) ? 255 : int'(bus.count_to);
            h   = e / 2;
            case (bus.wave_sel)
                2'd0: raw = cnt;
                2'd1: raw = (cnt > h) ? 255 : 0;
                2'd2: begin
                    t   = (cnt <= h) ? cnt : ((e - cnt) & 255);
                    raw = (2 * t > 255) ? 255 : 2 * t;
                end
                default: raw = m_lfsr;
            endcase
            m_sample <= (m_raw * m_env) / 256;
            m_raw    <= raw;
            if (cnt < m_prev) m_lfsr <= (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 184) : (m_lfsr / 2);
            m_prev <= cnt;
            tick  = (m_pre >= int'(bus.tick_div));
            m_pre <= tick ? 0 : m_pre + 1;
            rise  = bus.gate && (m_gq == 0);
            m_gq  <= int'(bus.gate);
            ne = m_env;
            ns = m_state;
            if (rise) ns = 1;
            else if (!bus.gate && m_state >= 1 && m_state <= 3) ns = 4;
            else begin
                case (m_state)
                    0: ne = 0;
                    1: if (tick) begin
                        ne = (as == 0 || m_env + as > 255) ? 255 : m_env + as;
                        if (ne == 255) ns = 2;
                    end
                    2: if (tick) begin
                        ne = (ds == 0 || m_env - ds < sus) ? sus : m_env - ds;
                        if (ne == sus) ns = 3;
                    end
                    3: ne = sus;
                    default: if (tick) begin
                        ne = (rs == 0 || m_env - rs < 0) ? 0 : m_env - rs;
                        if (ne == 0) ns = 0;
                    end
                endcase
            end
            m_env   <= ne;
            m_state <= ns;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("sample", int'(bus.sample), m_sample);
            check("env", int'(bus.env), m_env);
            check("env_state", int'(bus.env_state), m_state);
            check("active", int'(bus.active), (m_state != 0) ? 1 : 0);
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (n) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic collect(input int cycles);
        int last;
        q.delete();
        last = int'(bus.env);
        repeat (cycles) begin
            @(negedge clk);
            if (int'(bus.env) != last) begin
                last = int'(bus.env);
                q.push_back(last);
            end
        end
    endtask

    task automatic check_q(input string name, input int k, input int exp);
        check(name, (k < q.size()) ? q[k] : -1, exp);
    endtask

    task automatic hold_check(input string name, input int c, input int w, input int exp);
        bus.count    = 8'(c);
        bus.wave_sel = 2'(w);
        repeat (3) @(negedge clk);
        check(name, int'(bus.sample), exp);
    endtask

    function automatic int rnd_step();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int d1, d2, nxt, cur, wraps, since, e, found;
        bus.count = 8'd0; bus.count_to = 8'd0; bus.wave_sel = 2'd0; bus.gate = 1'b1;
        bus.attack_step = 8'd0; bus.decay_step = 8'd0; bus.release_step = 8'd0;
        bus.sustain_lvl = 8'd255; bus.tick_div = 16'd0;
        #1 rst = 1'b0;
        check_en = 1'b1;

        // Reset values with gate held high.
        repeat (3) @(negedge clk);
        check("reset_sample", int'(bus.sample), 0);
        check("reset_env", int'(bus.env), 0);
        check("reset_state", int'(bus.env_state), 0);
        check("reset_active", int'(bus.active), 0);
        #1 rst = 1'b1;

        // Saw ramp at full envelope: sample = count-1 two clocks later.
        d1 = 0; d2 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 20) begin
                check("saw_env_full", int'(bus.env), 255);
                check("saw_sustain", int'(bus.env_state), 3);
            end
            if (i >= 20 && i < 24) check("saw_lag", int'(bus.sample), (d2 == 0) ? 0 : d2 - 1);
            d2 = d1;
            d1 = (d1 + 1) & 255;
            bus.count = 8'(d1);
        end

        // Square and triangle at count_to = 99.
        bus.count_to = 8'd99;
        hold_check("tri_50", 50, 2, 97);
        hold_check("tri_49", 49, 2, 97);
        hold_check("tri_0", 0, 2, 0);
        hold_check("tri_99", 99, 2, 0);
        hold_check("tri_25", 25, 2, 49);
        hold_check("sq_49", 49, 1, 0);
        hold_check("sq_50", 50, 1, 254);
        hold_check("saw_99", 99, 0, 98);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.count    = 8'($urandom_range(0, 99));
            bus.wave_sel = 2'($urandom_range(0, 2));
        end

        // ADSR sequence.
        bus.release_step = 8'd0;
        bus.gate = 1'b0;
        repeat (4) @(negedge clk);
        check("adsr_idle", int'(bus.env_state), 0);
        bus.tick_div = 16'd3; bus.attack_step = 8'd64; bus.decay_step = 8'd32;
        bus.sustain_lvl = 8'd128; bus.release_step = 8'd16;
        bus.gate = 1'b1;
        collect(40);
        check("ad_len", q.size(), 8);
        for (int k = 0; k < 8; k++) check_q("ad_env", k, exp_ad[k]);
        check("ad_sustain", int'(bus.env_state), 3);
        bus.gate = 1'b0;
        collect(40);
        check("rel_len", q.size(), 8);
        for (int k = 0; k < 8; k++) check_q("rel_env", k, exp_rel[k]);
        check("rel_idle", int'(bus.env_state), 0);

        // Retrigger from release at env = 80.
        bus.gate = 1'b1;
        repeat (45) @(negedge clk);
        bus.gate = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (int'(bus.env) == 80) found = 1;
        end
        check("retrig_reach80", found, 1);
        bus.gate = 1'b1;
        collect(16);
        for (int k = 0; k < 3; k++) check_q("retrig_env", k, exp_ret[k]);

        // Noise: LFSR steps once per wrap, period 255.
        bus.wave_sel = 2'd3; bus.count_to = 8'd0; bus.count = 8'd0;
        bus.attack_step = 8'd0; bus.decay_step = 8'd0; bus.release_step = 8'd0;
        bus.sustain_lvl = 8'd255; bus.tick_div = 16'd0; bus.gate = 1'b1;
        do_reset(2);
        wraps = 0; since = 99;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            since++;
            if (since == 3) begin
                case (wraps)
                    1:   check("noise_w1", int'(bus.sample), 183);
                    2:   check("noise_w2", int'(bus.sample), 91);
                    3:   check("noise_w3", int'(bus.sample), 45);
                    255: check("noise_w255", int'(bus.sample), 0);
                    256: check("noise_w256", int'(bus.sample), 183);
                    default: ;
                endcase
            end
            if (wraps == 256 && since >= 3) break;
            cur = int'(bus.count);
            if (wraps < 3) nxt = (cur + 1) & 255;
            else begin
                bus.count_to = 8'd3;
                nxt = (cur >= 3) ? 0 : cur + 1;
            end
            if (nxt < cur) begin
                wraps++;
                since = 0;
            end
            bus.count = 8'(nxt);
        end
        check("noise_wraps", wraps, 256);

        // Mid-note reset during decay.
        bus.wave_sel = 2'd0; bus.count_to = 8'd0; bus.count = 8'd200; bus.gate = 1'b0;
        do_reset(2);
        bus.tick_div = 16'd3; bus.attack_step = 8'd0; bus.decay_step = 8'd1;
        bus.sustain_lvl = 8'd10; bus.release_step = 8'd0;
        bus.gate = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_decay", int'(bus.env_state), 2);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_env", int'(bus.env), 0);
        check("mid_rst_sample", int'(bus.sample), 0);
        check("mid_rst_state", int'(bus.env_state), 0);
        check("mid_rst_active", int'(bus.active), 0);
        bus.gate = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_stay_idle", int'(bus.env_state), 0);
        bus.gate = 1'b1;
        @(negedge clk);
        check("mid_restart", int'(bus.env_state), 1);

        // Random run against the model.
        do_reset(2);
        bus.tick_div = 16'($urandom_range(0, 3));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0)
                bus.count_to = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            e = (bus.count_to == 8'd0) ? 255 : int'(bus.count_to);
            bus.count    = 8'($urandom_range(0, e));
            bus.wave_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) bus.gate = ~bus.gate;
            if ($urandom_range(0, 49) == 0) bus.attack_step = 8'(rnd_step());
            if ($urandom_range(0, 49) == 0) bus.decay_step = 8'(rnd_step());
            if ($urandom_range(0, 49) == 0) bus.release_step = 8'(rnd_step());
            if ($urandom_range(0, 79) == 0) bus.sustain_lvl = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 699) == 0) begin
                #1 rst = 1'b0;
                @(negedge clk);
                #1 rst = 1'b1;
                bus.tick_div = 16'($urandom_range(0, 3));
            end
        end

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
